// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction register,
// bypass and IDCODE data registers, and boundary-scan chain control decodes.
// Strobes and TDO are decoded from the current state and active instruction
// so the boundary chain sees them in the same TCK cycle as the state.
// IDCODE bit 0 must be 1 so a host can tell an IDCODE from a bypass bit.
module tap_controller #(
  parameter int unsigned IR_W   = 3,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic            TCK,
  input  logic            TRSTn,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            bsc_tdo,
  output logic            ShiftDR,
  output logic            ClockDR,
  output logic            UpdateDR,
  output logic            Mode,
  output logic            TDO,
  output logic            TDO_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_out
);

  localparam int unsigned ID_W = 32;

  localparam logic [IR_W-1:0] INS_EXTEST  = IR_W'(0);
  localparam logic [IR_W-1:0] INS_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] INS_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_ALL_ONES = {IR_W{1'b1}};

  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0,
    ST_EX1_DR = 4'h1,
    ST_SH_DR  = 4'h2,
    ST_PAU_DR = 4'h3,
    ST_SEL_IR = 4'h4,
    ST_UPD_DR = 4'h5,
    ST_CAP_DR = 4'h6,
    ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8,
    ST_EX1_IR = 4'h9,
    ST_SH_IR  = 4'hA,
    ST_PAU_IR = 4'hB,
    ST_RTI    = 4'hC,
    ST_UPD_IR = 4'hD,
    ST_CAP_IR = 4'hE,
    ST_TLR    = 4'hF
  } tap_state_e;

  tap_state_e       state_q, state_d;
  logic [IR_W-1:0]  ir_sr_q, ir_sr_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             mode_q, mode_d;
  logic             byp_q, byp_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             sel_boundary;
  logic             sel_idcode;

  // Instruction class of the active instruction; unknown codes fall to bypass.
  always_comb begin
    sel_boundary = (ir_q == INS_EXTEST) || (ir_q == INS_SAMPLE);
    sel_idcode   = (ir_q == INS_IDCODE);
  end

  // TAP state register with synchronous reset into Test-Logic-Reset.
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // TAP next-state logic and same-cycle boundary/TDO decodes.
  always_comb begin
    state_d  = state_q;
    ShiftDR  = 1'b0;
    ClockDR  = 1'b0;
    UpdateDR = 1'b0;
    TDO_en   = 1'b0;
    TDO      = 1'b0;

    case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase

    case (state_q)
      ST_CAP_DR: begin
        ClockDR = sel_boundary;
      end
      ST_SH_DR: begin
        ShiftDR = sel_boundary;
        ClockDR = sel_boundary;
        TDO_en  = 1'b1;
        if (sel_boundary) begin
          TDO = bsc_tdo;
        end else if (sel_idcode) begin
          TDO = id_q[0];
        end else begin
          TDO = byp_q;
        end
      end
      ST_UPD_DR: begin
        UpdateDR = sel_boundary;
      end
      ST_SH_IR: begin
        TDO_en = 1'b1;
        TDO    = ir_sr_q[0];
      end
      default: begin
      end
    endcase
  end

  // Shift/capture next values; pause and other states hold every register.
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    byp_d   = byp_q;
    id_d    = id_q;

    case (state_q)
      ST_CAP_IR: ir_sr_d = IR_CAPTURE;
      ST_SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
      ST_CAP_DR: begin
        byp_d = 1'b0;
        id_d  = IDCODE;
      end
      ST_SH_DR: begin
        byp_d = TDI;
        id_d  = {TDI, id_q[ID_W-1:1]};
      end
      ST_UPD_IR: ir_d = ir_sr_q;
      default: begin
      end
    endcase

    // Entering Test-Logic-Reset forces IDCODE so it is active while in TLR.
    if (state_d == ST_TLR) begin
      ir_d = INS_IDCODE;
    end

    mode_d = (ir_d == INS_EXTEST);
  end

  // Datapath registers; reset aborts any scan in progress.
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      ir_sr_q <= IR_ALL_ONES;
      ir_q    <= INS_IDCODE;
      mode_q  <= 1'b0;
      byp_q   <= 1'b0;
      id_q    <= IDCODE;
    end else begin
      ir_sr_q <= ir_sr_d;
      ir_q    <= ir_d;
      mode_q  <= mode_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    tap_state = state_q;
    ir_out    = ir_q;
    Mode      = mode_q;
  end

endmodule
